// File: rtl/sm3_pkg.sv
// Shared constants and state encoding for the SM3 message padder.
package sm3_pkg;

    localparam int          SM3_BLK_WORDS = 16;
    localparam int          SM3_LEN_WIDX  = 14;
    localparam logic [7:0]  SM3_PAD_BYTE  = 8'h80;
    localparam logic [3:0]  SM3_LAST_FILL = 4'(SM3_LEN_WIDX - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD80,
        ZERO,
        LEN_HI,
        LEN_LO
    } pad_st_e;

    function automatic logic [2:0] f_popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/sm3_pad_core.sv
// SM3 message padder: byte-granular message beats in, padded 16-word blocks out
// (0x80 marker, zero fill, 64-bit big-endian bit length).
module sm3_pad_core
    import sm3_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] msg_inpt_d_i,
    input  logic [3:0]  msg_inpt_byte_vld_i,
    input  logic        msg_inpt_vld_i,
    input  logic        msg_inpt_lst_i,
    output logic        msg_inpt_rdy_o,
    output logic [31:0] pad_otpt_d_o,
    output logic        pad_otpt_vld_o,
    output logic        pad_otpt_lst_o,
    input  logic        pad_otpt_rdy_i
);

    // Keep valid bytes of the final beat, zero the rest, drop 0x80 into byte k.
    function automatic logic [31:0] f_pad_last(input logic [31:0] d, input logic [2:0] k);
        logic [31:0] w;
        case (k)
            3'd0:    w = {SM3_PAD_BYTE, 24'h0};
            3'd1:    w = {d[31:24], SM3_PAD_BYTE, 16'h0};
            3'd2:    w = {d[31:16], SM3_PAD_BYTE, 8'h0};
            3'd3:    w = {d[31:8], SM3_PAD_BYTE};
            default: w = d;
        endcase
        return w;
    endfunction

    pad_st_e            r_state;
    pad_st_e            w_state_nxt;
    logic [3:0]         r_widx;
    logic [CNT_W-1:0]   r_byte_cnt;

    logic [31:0]        r_otpt_d_p1;
    logic               r_otpt_lst_p1;
    logic               r_otpt_vld_p1;

    logic               w_load_ok;
    logic               w_acc;
    logic               w_load;
    logic [31:0]        w_word;
    logic               w_word_lst;
    logic [2:0]         w_cnt_add;
    logic               w_clr_cnt;
    logic [2:0]         w_k;
    logic [63:0]        w_len;

    assign w_load_ok      = !r_otpt_vld_p1 | pad_otpt_rdy_i;
    assign msg_inpt_rdy_o = !rst & ((r_state == IDLE) | (r_state == DATA)) & w_load_ok;
    assign w_acc          = msg_inpt_vld_i & msg_inpt_rdy_o;
    assign w_k            = f_popcnt4(msg_inpt_byte_vld_i);
    // Bit length wraps mod 2^64 by construction of the shift.
    assign w_len          = {{(64 - CNT_W){1'b0}}, r_byte_cnt} << 3;

    assign pad_otpt_d_o   = r_otpt_d_p1;
    assign pad_otpt_vld_o = r_otpt_vld_p1;
    assign pad_otpt_lst_o = r_otpt_lst_p1;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_word      = 32'h0;
        w_word_lst  = 1'b0;
        w_cnt_add   = 3'd0;
        w_clr_cnt   = 1'b0;
        case (r_state)
            IDLE, DATA: begin
                if (w_acc) begin
                    w_load    = 1'b1;
                    w_cnt_add = w_k;
                    if (!msg_inpt_lst_i) begin
                        w_word      = msg_inpt_d_i;
                        w_state_nxt = DATA;
                    end else if (w_k == 3'd4) begin
                        w_word      = msg_inpt_d_i;
                        w_state_nxt = PAD80;
                    end else begin
                        w_word      = f_pad_last(msg_inpt_d_i, w_k);
                        w_state_nxt = (r_widx == SM3_LAST_FILL) ? LEN_HI : ZERO;
                    end
                end
            end
            PAD80: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_word      = {SM3_PAD_BYTE, 24'h0};
                    w_state_nxt = (r_widx == SM3_LAST_FILL) ? LEN_HI : ZERO;
                end
            end
            ZERO: begin
                // Marker past word 13 spills the fill into an extra block via widx wrap.
                if (w_load_ok) begin
                    w_load = 1'b1;
                    if (r_widx == SM3_LAST_FILL) begin
                        w_state_nxt = LEN_HI;
                    end
                end
            end
            LEN_HI: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_word      = w_len[63:32];
                    w_state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_word      = w_len[31:0];
                    w_word_lst  = 1'b1;
                    w_clr_cnt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_widx        <= 4'd0;
            r_byte_cnt    <= '0;
            r_otpt_d_p1   <= 32'h0;
            r_otpt_lst_p1 <= 1'b0;
            r_otpt_vld_p1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_otpt_d_p1   <= w_word;
                r_otpt_lst_p1 <= w_word_lst;
                r_otpt_vld_p1 <= 1'b1;
                r_widx        <= r_widx + 4'd1;
            end else if (pad_otpt_rdy_i) begin
                r_otpt_vld_p1 <= 1'b0;
                r_otpt_lst_p1 <= 1'b0;
            end
            if (w_clr_cnt) begin
                r_byte_cnt <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(w_cnt_add);
            end
        end
    end

endmodule

// File: tb/tb_sm3_pad_core.sv
// Randomized bench for sm3_pad_core against a byte-level SM3 padding model.
module tb_sm3_pad_core;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] d;
        logic        lst;
    } ew_t;

    logic        clk;
    logic        rst;
    logic [31:0] msg_inpt_d_i;
    logic [3:0]  msg_inpt_byte_vld_i;
    logic        msg_inpt_vld_i;
    logic        msg_inpt_lst_i;
    logic        msg_inpt_rdy_o;
    logic [31:0] pad_otpt_d_o;
    logic        pad_otpt_vld_o;
    logic        pad_otpt_lst_o;
    logic        pad_otpt_rdy_i;

    int  total;
    int  bad;
    bit  stall;
    bit  gaps;
    bit  ignore;
    ew_t exp_q[$];

    sm3_pad_core #(.CNT_W(61)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .msg_inpt_d_i        (msg_inpt_d_i),
        .msg_inpt_byte_vld_i (msg_inpt_byte_vld_i),
        .msg_inpt_vld_i      (msg_inpt_vld_i),
        .msg_inpt_lst_i      (msg_inpt_lst_i),
        .msg_inpt_rdy_o      (msg_inpt_rdy_o),
        .pad_otpt_d_o        (pad_otpt_d_o),
        .pad_otpt_vld_o      (pad_otpt_vld_o),
        .pad_otpt_lst_o      (pad_otpt_lst_o),
        .pad_otpt_rdy_i      (pad_otpt_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && msg_inpt_vld_i && msg_inpt_rdy_o) begin
            assert (msg_inpt_lst_i ? (msg_inpt_byte_vld_i inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111})
                                   : (msg_inpt_byte_vld_i == 4'b1111))
            else $error("illegal byte_vld %b lst=%b", msg_inpt_byte_vld_i, msg_inpt_lst_i);
        end
    end

    // Expected stream: message bytes, 0x80, zeros up to 56 mod 64, 64-bit bit length.
    task automatic build_exp(input bq_t m);
        bq_t         q;
        logic [63:0] bl;
        ew_t         e;
        int          nw;
        q = m;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int j = 7; j >= 0; j--) q.push_back(bl[j*8 +: 8]);
        nw = q.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.d   = {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]};
            e.lst = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        pad_otpt_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pad_otpt_rdy_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bit          prev_hold;
        logic [31:0] prev_d;
        logic        prev_lst;
        ew_t         e;
        prev_hold = 1'b0;
        prev_d    = 32'h0;
        prev_lst  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || ignore) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk_eq("hold_vld", 64'(pad_otpt_vld_o), 64'd1);
                    chk_eq("hold_d", 64'(pad_otpt_d_o), 64'(prev_d));
                    chk_eq("hold_lst", 64'(pad_otpt_lst_o), 64'(prev_lst));
                end
                prev_hold = pad_otpt_vld_o && !pad_otpt_rdy_i;
                prev_d    = pad_otpt_d_o;
                prev_lst  = pad_otpt_lst_o;
                if (pad_otpt_vld_o && pad_otpt_rdy_i) begin
                    if (exp_q.size() == 0) begin
                        chk_eq("extra_word", 64'(pad_otpt_d_o), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk_eq("word", 64'(pad_otpt_d_o), 64'(e.d));
                        chk_eq("lst", 64'(pad_otpt_lst_o), 64'(e.lst));
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        msg_inpt_vld_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] bv, input logic lst);
        int c;
        if (gaps) idle_cycles($urandom_range(0, 2));
        msg_inpt_d_i        = d;
        msg_inpt_byte_vld_i = bv;
        msg_inpt_lst_i      = lst;
        msg_inpt_vld_i      = 1'b1;
        c = 0;
        forever begin
            @(negedge clk);
            if (msg_inpt_rdy_o) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            c++;
            if (c > 2000) begin
                $display("FAIL beat_timeout rdy_o stuck low");
                $fatal(1, "input handshake stalled");
            end
        end
        msg_inpt_vld_i = 1'b0;
        msg_inpt_lst_i = 1'b0;
    endtask

    // Invalid bytes of the final beat carry random garbage the padder must clear.
    task automatic send_msg(input bq_t m, input bit empty_tail);
        int          n;
        int          i;
        int          take;
        bit          tail;
        logic [31:0] d;
        n    = m.size();
        i    = 0;
        tail = (n % 4 == 0) && ((n == 0) || empty_tail);
        while (i < n) begin
            take = (n - i >= 4) ? 4 : n - i;
            d    = $urandom;
            for (int j = 0; j < take; j++) d[31-8*j -: 8] = m[i+j];
            send_beat(d, 4'(4'hF << (4 - take)), (i + take == n) && !tail);
            i += take;
        end
        if (tail) send_beat($urandom, 4'b0000, 1'b1);
    endtask

    task automatic run_msg(input bq_t m, input bit empty_tail);
        build_exp(m);
        send_msg(m, empty_tail);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 20000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk_eq("drain_left", 64'(exp_q.size()), 64'd0);
        idle_cycles(3);
    endtask

    function automatic bq_t rand_msg(input int n);
        bq_t q;
        for (int j = 0; j < n; j++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t abc;
        total  = 0;
        bad    = 0;
        stall  = 1'b0;
        gaps   = 1'b0;
        ignore = 1'b0;
        rst    = 1'b1;
        msg_inpt_d_i        = 32'h0;
        msg_inpt_byte_vld_i = 4'h0;
        msg_inpt_vld_i      = 1'b0;
        msg_inpt_lst_i      = 1'b0;
        abc = '{8'h61, 8'h62, 8'h63};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_vld", 64'(pad_otpt_vld_o), 64'd0);
        chk_eq("rst_d", 64'(pad_otpt_d_o), 64'd0);
        chk_eq("rst_lst", 64'(pad_otpt_lst_o), 64'd0);
        chk_eq("rst_rdy", 64'(msg_inpt_rdy_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("idle_rdy", 64'(msg_inpt_rdy_o), 64'd1);
        chk_eq("idle_vld", 64'(pad_otpt_vld_o), 64'd0);
        @(posedge clk);
        #1;

        run_msg(rand_msg(0), 1'b0);  drain();
        run_msg(abc, 1'b0);          drain();
        run_msg(rand_msg(55), 1'b0); drain();
        run_msg(rand_msg(56), 1'b0); drain();
        run_msg(rand_msg(64), 1'b0); drain();
        run_msg(rand_msg(64), 1'b1); drain();
        run_msg(rand_msg(60), 1'b0); drain();

        stall = 1'b1;
        gaps  = 1'b1;
        run_msg(abc, 1'b0);
        run_msg(rand_msg(64), 1'b0);
        for (int r = 0; r < 25; r++) begin
            run_msg(rand_msg($urandom_range(0, 130)), 1'($urandom_range(0, 1)));
        end
        drain();
        stall = 1'b0;
        gaps  = 1'b0;
        idle_cycles(2);

        ignore = 1'b1;
        for (int b = 0; b < 5; b++) send_beat($urandom, 4'b1111, 1'b0);
        idle_cycles(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("mid_rst_vld", 64'(pad_otpt_vld_o), 64'd0);
        chk_eq("mid_rst_d", 64'(pad_otpt_d_o), 64'd0);
        chk_eq("mid_rst_lst", 64'(pad_otpt_lst_o), 64'd0);
        chk_eq("mid_rst_rdy", 64'(msg_inpt_rdy_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ignore = 1'b0;
        run_msg(abc, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
